// File: rtl/sync_req_arbiter.sv
// Purpose : synchronise NUM_REQ async request lines, capture rising edges, round-robin grant one shared resource.
// Latency : request edge sampled at k -> pending after k+2 -> earliest grant after k+3; grant held until res_done.
// Backpres: none upstream (edges are latched, repeat edges while pending flag overrun); resource releases via res_done.
//
// Ports:
//   clk, n_rst     - system clock, asynchronous active-low reset
//   async_req      - asynchronous request lines, one request per rising edge
//   res_done       - one-cycle completion pulse from the shared resource
//   clear_overrun  - one-cycle clear of all sticky overrun bits
//   grant          - registered one-hot grant
//   grant_valid    - registered, high while a grant is held
//   grant_id       - binary index of the granted channel, 0 when idle
//   pending        - captured requests not yet granted
//   overrun        - sticky: a request edge arrived while that channel was already pending
module sync_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] async_req,
    input  logic               res_done,
    input  logic               clear_overrun,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_id,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] overrun
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;

    logic [NUM_REQ-1:0] sync1;
    logic [NUM_REQ-1:0] sync2;
    logic [NUM_REQ-1:0] hist;
    logic [NUM_REQ-1:0] rise;

    logic [IDW-1:0]     last_winner;
    logic [IDW-1:0]     cand;
    logic [IDW-1:0]     win_id;
    logic               found;

    logic [NUM_REQ-1:0] issue_vec;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               grant_valid_nxt;
    logic [IDW-1:0]     grant_id_nxt;
    logic [IDW-1:0]     last_winner_nxt;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= async_req;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;

    // Round-robin search: first pending channel at or after last_winner+1, wrapping.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDW'((int'(last_winner) + off) % NUM_REQ);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)    state_nxt = GRANT;
            GRANT:   if (res_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered grant outputs.
    always_comb begin
        issue_vec       = '0;
        grant_nxt       = grant;
        grant_valid_nxt = grant_valid;
        grant_id_nxt    = grant_id;
        last_winner_nxt = last_winner;
        case (state)
            IDLE: begin
                if (found) begin
                    issue_vec[win_id] = 1'b1;
                    grant_nxt         = '0;
                    grant_nxt[win_id] = 1'b1;
                    grant_valid_nxt   = 1'b1;
                    grant_id_nxt      = win_id;
                    last_winner_nxt   = win_id;
                end
            end
            GRANT: begin
                if (res_done) begin
                    grant_nxt       = '0;
                    grant_valid_nxt = 1'b0;
                    grant_id_nxt    = '0;
                end
            end
            default: begin
                grant_nxt       = '0;
                grant_valid_nxt = 1'b0;
                grant_id_nxt    = '0;
            end
        endcase
    end

    // Reset pointer to the last channel so channel 0 wins the first arbitration.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_winner <= IDW'(NUM_REQ - 1);
        end else begin
            grant       <= grant_nxt;
            grant_valid <= grant_valid_nxt;
            grant_id    <= grant_id_nxt;
            last_winner <= last_winner_nxt;
        end
    end

    // A rise coinciding with its own grant re-arms pending (served later);
    // a rise onto an uncleared pending bit is lost and flagged. Set beats clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~issue_vec) | rise;
            overrun <= (clear_overrun ? '0 : overrun) | (rise & pending & ~issue_vec);
        end
    end

endmodule

// File: tb/tb_sync_req_arbiter.sv
module tb_sync_req_arbiter;

    logic       clk;
    logic       n_rst;
    logic [3:0] async_req;
    logic       res_done;
    logic       clear_overrun;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] pending;
    logic [3:0] overrun;

    int n_chk  = 0;
    int n_fail = 0;

    sync_req_arbiter #(.NUM_REQ(4)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .async_req     (async_req),
        .res_done      (res_done),
        .clear_overrun (clear_overrun),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .pending       (pending),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       clr;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] ovr;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mk(logic [3:0] req, logic done, logic clr, logic [3:0] gnt,
                                logic vld, logic [1:0] id, logic [3:0] pend, logic [3:0] ovr);
        vec_t v;
        v.req = req; v.done = done; v.clr = clr; v.gnt = gnt;
        v.vld = vld; v.id = id; v.pend = pend; v.ovr = ovr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic v,
                             input logic [1:0] id, input logic [3:0] p, input logic [3:0] o);
        check({tag, ".grant"},       32'(grant),       32'(g));
        check({tag, ".grant_valid"}, 32'(grant_valid), 32'(v));
        check({tag, ".grant_id"},    32'(grant_id),    32'(id));
        check({tag, ".pending"},     32'(pending),     32'(p));
        check({tag, ".overrun"},     32'(overrun),     32'(o));
    endtask

    // Drive inputs for one clock edge, then sample 1 time unit after it.
    task automatic cyc(input logic [3:0] req, input logic done, input logic clr);
        async_req     = req;
        res_done      = done;
        clear_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst         = 1'b0;
        async_req     = '0;
        res_done      = 1'b0;
        clear_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst         = 1'b0;
        async_req     = '0;
        res_done      = 1'b0;
        clear_overrun = 1'b0;
        #3;
        check_out("reset", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);
        do_reset();

        // All four channels rise together; each grant completed 3 cycles after issue.
        tbl[0]  = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[1]  = mk(4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[2]  = mk(4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[3]  = mk(4'b1111, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000);
        tbl[4]  = mk(4'b1111, 0, 0, 4'b0001, 1, 0, 4'b1110, 4'b0000);
        tbl[5]  = mk(4'b1111, 0, 0, 4'b0001, 1, 0, 4'b1110, 4'b0000);
        tbl[6]  = mk(4'b1111, 0, 0, 4'b0001, 1, 0, 4'b1110, 4'b0000);
        tbl[7]  = mk(4'b1111, 1, 0, 4'b0000, 0, 0, 4'b1110, 4'b0000);
        tbl[8]  = mk(4'b1111, 0, 0, 4'b0010, 1, 1, 4'b1100, 4'b0000);
        tbl[9]  = mk(4'b1111, 0, 0, 4'b0010, 1, 1, 4'b1100, 4'b0000);
        tbl[10] = mk(4'b1111, 0, 0, 4'b0010, 1, 1, 4'b1100, 4'b0000);
        tbl[11] = mk(4'b1111, 1, 0, 4'b0000, 0, 0, 4'b1100, 4'b0000);
        tbl[12] = mk(4'b1111, 0, 0, 4'b0100, 1, 2, 4'b1000, 4'b0000);
        tbl[13] = mk(4'b1111, 0, 0, 4'b0100, 1, 2, 4'b1000, 4'b0000);
        tbl[14] = mk(4'b1111, 0, 0, 4'b0100, 1, 2, 4'b1000, 4'b0000);
        tbl[15] = mk(4'b1111, 1, 0, 4'b0000, 0, 0, 4'b1000, 4'b0000);
        tbl[16] = mk(4'b1111, 0, 0, 4'b1000, 1, 3, 4'b0000, 4'b0000);
        tbl[17] = mk(4'b1111, 0, 0, 4'b1000, 1, 3, 4'b0000, 4'b0000);
        tbl[18] = mk(4'b1111, 0, 0, 4'b1000, 1, 3, 4'b0000, 4'b0000);
        tbl[19] = mk(4'b1111, 1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[20] = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[21] = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[22] = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[23] = mk(4'b0011, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[24] = mk(4'b0011, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[25] = mk(4'b0011, 0, 0, 4'b0000, 0, 0, 4'b0011, 4'b0000);
        tbl[26] = mk(4'b0011, 0, 0, 4'b0001, 1, 0, 4'b0010, 4'b0000);
        tbl[27] = mk(4'b0011, 1, 0, 4'b0000, 0, 0, 4'b0010, 4'b0000);
        tbl[28] = mk(4'b0011, 0, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000);
        tbl[29] = mk(4'b0011, 1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[30] = mk(4'b0011, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);

        for (int i = 0; i < 31; i++) begin
            cyc(tbl[i].req, tbl[i].done, tbl[i].clr);
            check_out($sformatf("rr_row%0d", i), tbl[i].gnt, tbl[i].vld, tbl[i].id,
                      tbl[i].pend, tbl[i].ovr);
        end

        // Overrun: ch1 rises, falls, rises again while ch0 holds the resource.
        do_reset();
        cyc(4'b0001, 0, 0);
        cyc(4'b0001, 0, 0);
        cyc(4'b0001, 0, 0);
        cyc(4'b0001, 0, 0);
        check_out("ovr_g0", 4'b0001, 1'b1, 2'd0, 4'b0000, 4'b0000);
        cyc(4'b0011, 0, 0);
        cyc(4'b0011, 0, 0);
        cyc(4'b0001, 0, 0);
        cyc(4'b0001, 0, 0);
        cyc(4'b0011, 0, 0);
        cyc(4'b0011, 0, 0);
        cyc(4'b0011, 0, 0);
        check_out("ovr_set", 4'b0001, 1'b1, 2'd0, 4'b0010, 4'b0010);
        cyc(4'b0011, 1, 0);
        check_out("ovr_done0", 4'b0000, 1'b0, 2'd0, 4'b0010, 4'b0010);
        cyc(4'b0011, 0, 0);
        check_out("ovr_g1", 4'b0010, 1'b1, 2'd1, 4'b0000, 4'b0010);
        cyc(4'b0011, 1, 0);
        cyc(4'b0011, 0, 0);
        cyc(4'b0011, 0, 0);
        check_out("ovr_single", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0010);
        cyc(4'b0011, 0, 1);
        check_out("ovr_clr", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Ch0 re-rises on the exact edge its grant is issued.
        do_reset();
        cyc(4'b0010, 0, 0);
        cyc(4'b0010, 0, 0);
        cyc(4'b0010, 0, 0);
        cyc(4'b0010, 0, 0);
        check_out("same_g1", 4'b0010, 1'b1, 2'd1, 4'b0000, 4'b0000);
        cyc(4'b0011, 0, 0);
        cyc(4'b0011, 0, 0);
        cyc(4'b0011, 0, 0);
        check_out("same_p0", 4'b0010, 1'b1, 2'd1, 4'b0001, 4'b0000);
        cyc(4'b0010, 0, 0);
        cyc(4'b0010, 0, 0);
        cyc(4'b0011, 0, 0);
        cyc(4'b0011, 1, 0);
        check_out("same_idle", 4'b0000, 1'b0, 2'd0, 4'b0001, 4'b0000);
        cyc(4'b0011, 0, 0);
        check_out("same_g0a", 4'b0001, 1'b1, 2'd0, 4'b0001, 4'b0000);
        cyc(4'b0011, 1, 0);
        check_out("same_rel", 4'b0000, 1'b0, 2'd0, 4'b0001, 4'b0000);
        cyc(4'b0011, 0, 0);
        check_out("same_g0b", 4'b0001, 1'b1, 2'd0, 4'b0000, 4'b0000);

        // Reset asserted mid-grant with pending=1010.
        do_reset();
        cyc(4'b1011, 0, 0);
        cyc(4'b1011, 0, 0);
        cyc(4'b1011, 0, 0);
        cyc(4'b1011, 0, 0);
        check_out("rst_pre", 4'b0001, 1'b1, 2'd0, 4'b1010, 4'b0000);
        n_rst     = 1'b0;
        async_req = 4'b0000;
        #1;
        check_out("rst_async", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) cyc(4'b0000, 0, 0);
        check_out("rst_quiet", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);

        // One-cycle pulse on ch2 after reset: pending after k+2, grant after k+3.
        cyc(4'b0100, 0, 0);
        cyc(4'b0000, 0, 0);
        check_out("p2_k1", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);
        cyc(4'b0000, 0, 0);
        check_out("p2_k2", 4'b0000, 1'b0, 2'd0, 4'b0100, 4'b0000);
        cyc(4'b0000, 0, 0);
        check_out("p2_k3", 4'b0100, 1'b1, 2'd2, 4'b0000, 4'b0000);
        cyc(4'b0000, 1, 0);
        check_out("p2_done", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);
        cyc(4'b0000, 0, 0);
        check_out("p2_after", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
